// File: rtl/seq_pkg.sv
// Shared sequencer definitions: step geometry, pitch width and the LED scan FSM states.
package seq_pkg;

   localparam int NUM_BEATS = 16;
   localparam int PITCH_W   = 4;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } led_state_t;

   typedef logic [$clog2(NUM_BEATS)-1:0] beat_idx_t;

endpackage

// File: rtl/led_row_decode.sv
// Combinational decode of one grid row from the frame snapshot into column lit bits.
// With LED_PLAYHEAD_EN defined, the playhead cell is inverted.
module led_row_decode
   import seq_pkg::*;
#(
   parameter int NUM_ROWS = 4,
   parameter int NUM_COLS = 4,
   parameter int ROW_W    = 2,
   parameter int IDX_W    = 4
) (
   input  logic [NUM_ROWS*NUM_COLS*PITCH_W-1:0] beats,
   input  logic [IDX_W-1:0]                     beat_count,
   input  logic [ROW_W-1:0]                     row,
   output logic [NUM_COLS-1:0]                  lit
);

   // NOTE: lit gets a default before the loop so no path through this block leaves it unassigned (no latch).
   always_comb begin
      lit = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         lit[c] = |beats[(int'(row) * NUM_COLS + c) * PITCH_W +: PITCH_W];
`ifdef LED_PLAYHEAD_EN
         lit[c] = lit[c] ^ (beat_count == IDX_W'(int'(row) * NUM_COLS + c));
`endif
      end
   end

`ifdef LED_PLAYHEAD_EN
`else
   logic unused_beat_count;
   assign unused_beat_count = ^beat_count;
`endif

endmodule

// File: rtl/led_matrix_driver.sv
// Time-multiplexed 4x4 LED grid driver: BLANK/DRIVE row scan, per-frame input snapshot, duty control.
// Optional playhead highlight is enabled with LED_PLAYHEAD_EN.
module led_matrix_driver
   import seq_pkg::*;
#(
   parameter int NUM_ROWS     = 4,
   parameter int NUM_COLS     = 4,
   parameter int ROW_CYCLES   = 3000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_ROWS*NUM_COLS*PITCH_W-1:0]   beats,
   input  logic [$clog2(NUM_ROWS*NUM_COLS)-1:0]   beat_count,
   input  logic [2:0]                             brightness,
   output logic [NUM_ROWS-1:0]                    row_n,
   output logic [NUM_COLS-1:0]                    col,
   output logic                                   frame_start
);

   localparam int IDX_W   = $clog2(NUM_ROWS * NUM_COLS);
   localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int CNT_MAX = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BEATS_W = NUM_ROWS * NUM_COLS * PITCH_W;

   localparam logic [CNT_W-1:0] DUTY_STEP = CNT_W'(ROW_CYCLES / 8);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRIVE_END = CNT_W'(ROW_CYCLES - 1);
   localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_ROWS - 1);

   led_state_t          state_q, state_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [BEATS_W-1:0]  snap_beats_q, snap_beats_d;
   logic [IDX_W-1:0]    snap_bc_q, snap_bc_d;
   logic [2:0]          snap_bright_q, snap_bright_d;

   logic [NUM_ROWS-1:0] row_n_q, row_n_d;
   logic [NUM_COLS-1:0] col_q, col_d;
   logic                frame_start_q, frame_start_d;

   logic [NUM_COLS-1:0] lit;
   logic [CNT_W-1:0]    duty_limit;

   led_row_decode #(
      .NUM_ROWS (NUM_ROWS),
      .NUM_COLS (NUM_COLS),
      .ROW_W    (ROW_W),
      .IDX_W    (IDX_W)
   ) u_decode (
      .beats      (snap_beats_q),
      .beat_count (snap_bc_q),
      .row        (row_q),
      .lit        (lit)
   );

   // Brightness 7 yields exactly ROW_CYCLES, so the columns stay on for the whole DRIVE window.
   assign duty_limit = (CNT_W'(snap_bright_q) + CNT_W'(1)) * DUTY_STEP;

   always_comb begin
      state_d       = state_q;
      row_d         = row_q;
      cnt_d         = cnt_q + CNT_W'(1);
      snap_beats_d  = snap_beats_q;
      snap_bc_d     = snap_bc_q;
      snap_bright_d = snap_bright_q;
      row_n_d       = '1;
      col_d         = '0;
      frame_start_d = 1'b0;

      unique case (state_q)
         BLANK: begin
            if (row_q == '0 && cnt_q == '0) begin
               snap_beats_d  = beats;
               snap_bc_d     = beat_count;
               snap_bright_d = brightness;
               frame_start_d = 1'b1;
            end
            if (cnt_q == BLANK_END) begin
               state_d = DRIVE;
               cnt_d   = '0;
            end
         end
         DRIVE: begin
            row_n_d = ~(NUM_ROWS'(1) << row_q);
            col_d   = (cnt_q < duty_limit) ? lit : '0;
            if (cnt_q == DRIVE_END) begin
               state_d = BLANK;
               cnt_d   = '0;
               row_d   = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
            end
         end
         default: begin
            state_d = BLANK;
            cnt_d   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= BLANK;
         row_q         <= '0;
         cnt_q         <= '0;
         snap_beats_q  <= '0;
         snap_bc_q     <= '0;
         snap_bright_q <= '0;
         row_n_q       <= '1;
         col_q         <= '0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         cnt_q         <= cnt_d;
         snap_beats_q  <= snap_beats_d;
         snap_bc_q     <= snap_bc_d;
         snap_bright_q <= snap_bright_d;
         row_n_q       <= row_n_d;
         col_q         <= col_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign row_n       = row_n_q;
   assign col         = col_q;
   assign frame_start = frame_start_q;

endmodule

// File: doc/led_matrix_driver.md
# led_matrix_driver

Time-multiplexed driver for the 4x4 LED grid that shares the sequencer's step layout with the button matrix. It is the output counterpart of the button matrix scanner: it selects one row at a time, drives the column lines with that row's step pattern, and optionally highlights the playhead step. It sits beside the audio controller, fed by the model's `beats` register and the sequencer's `beat_count`.

## Interface
Parameters:
- `NUM_ROWS`, 4, grid rows; also the number of row-select lines.
- `NUM_COLS`, 4, grid columns; also the number of column-drive lines.
- `ROW_CYCLES`, 3000, clocks each row is in DRIVE; must be a multiple of 8.
- `BLANK_CYCLES`, 16, all-off clocks before each row, for anti-ghosting.

Ports:
- `clk`  in  1  system clock, 12 MHz.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `beats`  in  NUM_ROWS*NUM_COLS*4  step pitches; step i is `beats[i*4 +: 4]`; a nonzero pitch means the step is active.
- `beat_count`  in  $clog2(NUM_ROWS*NUM_COLS)  current playhead step.
- `brightness`  in  3  duty level 0..7; duty is (brightness+1)/8.
- `row_n`  out  NUM_ROWS  row select, active-low, one-cold.
- `col`  out  NUM_COLS  column drive, active-high.
- `frame_start`  out  1  one-cycle pulse at the start of each frame.

## Operation
- Step index mapping: row = i / NUM_COLS, col = i % NUM_COLS. This matches the button matrix (`button_index = row*4 + col`).
- FSM states and transitions:
  - BLANK: `row_n` all 1, `col` all 0. Stays in BLANK for BLANK_CYCLES clocks, then goes to DRIVE.
  - DRIVE: `row_n[row]` = 0. Stays in DRIVE for ROW_CYCLES clocks, then returns to BLANK with `row` incremented.
  - Row wrap: row NUM_ROWS-1 wraps to 0.
- Frame snapshot:
  - On the first BLANK cycle of row 0, latch `beats`, `beat_count` and `brightness`.
  - Assert `frame_start` in that same cycle.
  - All rows of the frame use only the snapshot. Input changes mid-frame never cause tearing.
- Cell value: `lit[c]` = (snapshot pitch of step row*NUM_COLS+c != 0).
- Duty:
  - The DRIVE counter `dcnt` runs 0..ROW_CYCLES-1.
  - `col = lit` while `dcnt < (bright+1)*(ROW_CYCLES/8)`, otherwise `col` = 0.
  - At brightness 7, `col` is on for the full DRIVE window.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Timing
- Reset values: `row_n` = all 1, `col` = 0, `frame_start` = 0, state = BLANK, row = 0, counters = 0, snapshot = 0.
- Reset deasserted mid-row: the driver restarts at BLANK of row 0. `frame_start` pulses on the first clock after `rst_n` rises.
- Row period is BLANK_CYCLES + ROW_CYCLES clocks; frame period is NUM_ROWS times that.
  - With defaults: 3016 clocks per row, 12064 per frame, about 995 Hz frame rate at 12 MHz.
- Output latency: `row_n` and `col` change on the clock edge after the state or counter transition. Every output changes by exactly one registered step.
- A row's select and its columns change only inside BLANK, so two rows are never active at once.
- Simultaneous events: an input change in the snapshot cycle is captured as the value present at that edge. The new value is visible in DRIVE of row 0 of the same frame.
- Out-of-range `beat_count` cannot occur (full-width index); all values are valid.

## Configuration
- `LED_PLAYHEAD_EN` defined:
  - The playhead cell is inverted: `lit[c] ^= (snapshot_beat_count == row*NUM_COLS+c)`.
  - An active step under the playhead shows dark; an inactive step under the playhead shows lit.
- Undefined: `lit` is the pattern only, and `beat_count` is unused.

## Structure
- Shared package `seq_pkg`:
  - `NUM_BEATS` and `PITCH_W` (4).
  - FSM typedef `led_state_t {BLANK, DRIVE}`.
  - `beat_idx_t` = logic [$clog2(NUM_BEATS)-1:0].
- Sub-module `led_row_decode`: a purely combinational decoder that turns the snapshot, row and playhead into `lit[NUM_COLS-1:0]`. The FSM, counters and duty compare stay in `led_matrix_driver`.

## Test plan
- Reset: hold `rst_n` = 0 for 5 clocks -> `row_n` = 4'hF, `col` = 0, `frame_start` = 0. Release -> `frame_start` = 1 for exactly one cycle, then `row_n` = 4'hF for 16 clocks, then 4'b1110.
- Pattern: `beats` with steps 0, 5, 10, 15 = pitch 3, brightness = 7, `LED_PLAYHEAD_EN` off -> across rows 0..3 `col` = 4'b0001, 4'b0010, 4'b0100, 4'b1000, each for exactly 3000 clocks, separated by 16 all-off clocks.
- Duty: brightness = 1, step 0 active -> in row 0, `col` = 4'b0001 for 750 clocks, then 0 for 2250 clocks.
- Snapshot: change `beats` from all-zero to all-active mid row 1 -> rows 1..3 stay 0 this frame. The next frame shows `col` = 4'hF on every row, with `frame_start` marking the boundary.
- Playhead (`LED_PLAYHEAD_EN` on): all steps inactive, `beat_count` = 6 -> only row 1 shows `col` = 4'b0100. With all steps active -> row 1 shows `col` = 4'b1011.
- Reset mid-operation: assert `rst_n` during DRIVE of row 2 -> outputs return to their reset values asynchronously, within that cycle. After release, scanning restarts at row 0.
